vedic_mul_sched: RTL
====================

Name: vedic_mul_sched

Overview:
- Shares one combinational vedic8 (8x8 -> 16) multiplier among NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes, 2-stage pipeline (operand register, product register).
- Each product returns tagged with the requester id.
- Sits between the integer lanes and the multiplier datapath, so the lanes do not need their own multiplier instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester tag width; must equal clog2(NUM_REQ), with a minimum of 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_a  in  8*NUM_REQ  multiplicand; requester i uses bits [8i+7:8i]
- req_b  in  8*NUM_REQ  multiplier; requester i uses bits [8i+7:8i]
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_W  index of the requester that owns rsp_prod
- rsp_prod  out  16  unsigned product a*b
- busy  out  1  high when either pipeline stage holds data

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid, s2_valid, rsp_valid, busy = 0.
  - rsp_id, rsp_prod = 0.
  - RR pointer = 0, so requester 0 has top priority on the first grant.
  - req_ready = 0 while in reset.
- Reset mid-operation discards all in-flight transactions; no response is issued for them.
- Stage advance conditions:
  - adv2 = !s2_valid | rsp_ready
  - adv1 = !s1_valid | adv2
- Arbitration (combinational):
  - Search starts at pointer and wraps modulo NUM_REQ; the first i with req_valid[i] wins, giving grant g.
  - req_ready[g] = adv1; all other req_ready bits = 0.
- Accept:
  - Occurs when req_valid[g] & req_ready[g].
  - Stage 1 captures a, b and id=g.
  - Pointer becomes (g+1) mod NUM_REQ.
- Pointer holds when no transfer occurs, including stalled cycles.
- Stage 1 -> stage 2:
  - When s1_valid & adv2, stage 2 captures vedic8(s1_a, s1_b) and s1_id.
  - s2_valid is set from s1_valid whenever adv2.
- Output: rsp_valid = s2_valid, rsp_prod = s2_prod, rsp_id = s2_id, all driven directly from registers.
- Latency: a request accepted at edge N produces rsp_valid high after edge N+2 when there is no backpressure.
- Throughput: one product per cycle when requesters keep requesting.
- Backpressure:
  - While rsp_valid & !rsp_ready, rsp_id and rsp_prod stay stable.
  - Stage 1 holds if full; req_ready stays low if stage 1 is full.
  - No data loss and no duplication.
- Requester obligations:
  - Once valid is asserted, hold valid, a and b stable until accepted.
  - Retracting a request is not permitted; verification flags it.
- Simultaneous events:
  - Same cycle accept and stage 1 -> stage 2 move is allowed; stage 1 is overwritten after its old contents advance.
  - A response handshake and a new stage 2 load in the same cycle are allowed.
- Fairness: with every requester continuously valid, grants rotate 0,1,2,3,0,... and no requester waits more than NUM_REQ-1 accepts.
- Arithmetic:
  - Unsigned only; the full 16-bit product, with no truncation.
  - 0xFF*0xFF = 0xFE01.
- busy = s1_valid | s2_valid.

Decomposition:
- Package vedic_pkg:
  - OP_W=8, PROD_W=16.
  - Request record type {a[7:0], b[7:0], id}.
  - Response record type {prod[15:0], id}.
- Sub-module mul_rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, encoded index, any_grant.
- vedic8 is instantiated once, unmodified, between the stage 1 and stage 2 registers.

Test Plan:
- Single request: req0 a=0x0F, b=0x0F, rsp_ready=1 -> accepted cycle 0; rsp_valid at cycle 2 with id=0, prod=0x00E1; busy low at cycle 3.
- All four requesters valid continuously, a=i+1, b=0x10 -> grants in order 0,1,2,3,0; back-to-back responses prod 0x0010, 0x0020, 0x0030, 0x0040; rsp_valid high every cycle.
- Corner operands: 0xFF*0xFF -> 0xFE01; 0x00*0xA5 -> 0x0000; 0x80*0x02 -> 0x0100; 0x01*0xFF -> 0x00FF.
- Backpressure:
  - Stimulus: req1 and req2 valid; rsp_ready held low 5 cycles after the first rsp_valid.
  - Response: rsp_prod and rsp_id stable throughout the stall; req_ready all 0 once stage 1 fills.
  - After release, both products delivered in order (id1, then id2) with none lost or repeated.
- Reset mid-flight: assert rst_n=0 with both stages full -> outputs 0 immediately (asynchronously); after release, requester 0 wins over requester 3 when both are valid.
- Random soak: 10k random valid/a/b/rsp_ready patterns -> each accepted request yields exactly one response whose product matches a reference model a*b with the correct id, and fairness holds with starvation of at most 3 accepts.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared widths and record types for the shared vedic multiplier scheduler.
// Tags are sized for the largest supported requester count (8).
package vedic_pkg;

  localparam int OP_W     = 8;
  localparam int PROD_W   = 16;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic [OP_W-1:0]     a;
    logic [OP_W-1:0]     b;
    logic [MAX_ID_W-1:0] id;
  } mul_req_t;

  typedef struct packed {
    logic [PROD_W-1:0]   prod;
    logic [MAX_ID_W-1:0] id;
  } mul_rsp_t;

endpackage

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// idx/any_grant report the winner regardless of enable; grant is gated by it.
module mul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_grant
);

  int          j;
  logic [ID_W-1:0] jj;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j  = (int'(ptr) + k) % NUM_REQ;
      jj = ID_W'(j);
      if (!any_grant && req[jj]) begin
        any_grant = 1'b1;
        idx       = jj;
      end
    end
    if (any_grant && enable) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/vedic8.sv
// Purely combinational 8x8 unsigned multiplier built from Urdhva-Tiryagbhyam
// 2x2 cells, composed recursively into 4x4 and then 8x8.
module vedic8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] t;
    logic [1:0] u;
    t = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    u = {1'b0, x[1] & y[1]} + {1'b0, t[1]};
    return {u, t[0], x[0] & y[0]};
  endfunction

  function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = v2(x[1:0], y[1:0]);
    q1 = v2(x[3:2], y[1:0]);
    q2 = v2(x[1:0], y[3:2]);
    q3 = v2(x[3:2], y[3:2]);
    return {4'b0, q0} + ({4'b0, q1} << 2) + ({4'b0, q2} << 2) + {q3, 4'b0};
  endfunction

  logic [7:0] q0, q1, q2, q3;

  always_comb begin
    q0 = v4(a[3:0], b[3:0]);
    q1 = v4(a[7:4], b[3:0]);
    q2 = v4(a[3:0], b[7:4]);
    q3 = v4(a[7:4], b[7:4]);
    p  = {8'b0, q0} + ({8'b0, q1} << 4) + ({8'b0, q2} << 4) + {q3, 8'b0};
  end

endmodule

// File: rtl/vedic_mul_sched.sv
// Shares one vedic8 multiplier among NUM_REQ requesters with round-robin
// arbitration and a two-stage (operand, product) valid/ready pipeline.
module vedic_mul_sched
  import vedic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_a,
  input  logic [OP_W*NUM_REQ-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [PROD_W-1:0]         rsp_prod,
  output logic                      busy
);

  logic              adv1, adv2, accept, any_grant, arb_en;
  logic              s1_valid, s2_valid;
  logic [ID_W-1:0]   ptr, g_idx;
  logic [NUM_REQ-1:0] grant;
  logic [PROD_W-1:0] mul_p;
  mul_req_t          s1, sel;
  mul_rsp_t          s2;
  logic              unused_id_bits;

  assign adv2   = !s2_valid || rsp_ready;
  assign adv1   = !s1_valid || adv2;
  // Gating with rst_n keeps every req_ready low while reset is held.
  assign arb_en = adv1 && rst_n;
  assign accept = any_grant && arb_en;

  mul_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (arb_en),
    .grant     (grant),
    .idx       (g_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel    = '0;
    sel.a  = req_a[OP_W*g_idx +: OP_W];
    sel.b  = req_b[OP_W*g_idx +: OP_W];
    sel.id = MAX_ID_W'(g_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + ID_W'(1);
    end
  end

  // Stage 1 may be refilled in the same cycle its old contents move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) s1 <= sel;
    end
  end

  vedic8 u_mul (
    .a (s1.a),
    .b (s1.b),
    .p (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2.prod <= mul_p;
        s2.id   <= s1.id;
      end
    end
  end

  assign rsp_valid      = s2_valid;
  assign rsp_prod       = s2.prod;
  assign rsp_id         = s2.id[ID_W-1:0];
  assign busy           = s1_valid || s2_valid;
  assign unused_id_bits = ^(s2.id >> ID_W);

endmodule
